// File: rtl/inter_read_slave.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | inter_read_slave: read responder for one interconnect slave port,     |
// | fronting a 1-cycle memory plus wait states, with a last-address buffer|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module inter_read_slave #(
  parameter int DATA_WIDTH       = 32,
  parameter int SLAVE_ADDR_WIDTH = 10,
  parameter int WAIT_STATES      = 0,
  parameter int CACHE_EN         = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        slave_data_req_i,
  input  logic [SLAVE_ADDR_WIDTH-1:0] slave_data_addr_i,
  output logic [DATA_WIDTH-1:0]       slave_data_rdata_o,
  output logic                        slave_data_gnt_o,
  output logic                        mem_en_o,
  output logic [SLAVE_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0]       mem_rdata_i,
  input  logic                        invalidate_i,
  output logic                        busy_o
);

  localparam int                CNT_W    = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic              CACHE_ON = (CACHE_EN != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [SLAVE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        buf_valid_q, buf_valid_d;
  logic [SLAVE_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;

  logic hit;
  logic addr_match;
  logic wait_keep;

  assign hit        = CACHE_ON & buf_valid_q & (buf_addr_q == slave_data_addr_i) & ~invalidate_i;
  assign addr_match = (slave_data_addr_i == addr_q);
  assign wait_keep  = slave_data_req_i & addr_match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (slave_data_req_i) state_d = hit ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (!wait_keep)          state_d = S_IDLE;
        else if (cnt_q == '0)    state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    case (state_q)
      S_IDLE: begin
        if (slave_data_req_i) begin
          addr_d = slave_data_addr_i;
          if (!hit) cnt_d = CNT_INIT;
        end
      end
      S_WAIT: begin
        // An aborted wait leaves data and buffer untouched.
        if (wait_keep) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            data_d      = mem_rdata_i;
            buf_addr_d  = addr_q;
            buf_valid_d = CACHE_ON;
          end
        end
      end
      default: ;
    endcase
    // A write-path invalidate wins over a same-cycle capture.
    if (invalidate_i) buf_valid_d = 1'b0;
  end

  always_comb begin
    slave_data_gnt_o = 1'b0;
    mem_en_o         = 1'b0;
    mem_addr_o       = addr_q;
    busy_o           = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_o     = 1'b0;
        mem_addr_o = slave_data_addr_i;
        mem_en_o   = reset & slave_data_req_i & ~hit;
      end
      S_RESP: begin
        slave_data_gnt_o = slave_data_req_i & addr_match;
      end
      default: ;
    endcase
  end

  assign slave_data_rdata_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_inter_read_slave.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_inter_read_slave: directed and randomized checks of inter_read_slave|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_inter_read_slave;

  localparam int WS_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_a, inv_a, gnt_a, en_a, busy_a;
  logic [9:0]  addr_a, maddr_a;
  logic [31:0] rdata_a, mrd_a;
  logic        req_b, inv_b, gnt_b, en_b, busy_b;
  logic [9:0]  addr_b, maddr_b;
  logic [31:0] rdata_b, mrd_b;

  logic [31:0] mem [0:1023];
  logic [31:0] junk_q;

  // Memory model: data valid exactly WAIT_STATES+1 cycles after the strobe, junk otherwise.
  logic [2:0]  pv_a = 3'b000;
  logic [9:0]  pa_a [0:2];
  logic        pv_b = 1'b0;
  logic [9:0]  pa_b;

  always @(posedge clk) begin
    junk_q  <= $urandom;
    pv_a    <= {pv_a[1:0], en_a};
    pa_a[0] <= maddr_a;
    pa_a[1] <= pa_a[0];
    pa_a[2] <= pa_a[1];
    pv_b    <= en_b;
    pa_b    <= maddr_b;
  end

  assign mrd_a = pv_a[2] ? mem[pa_a[2]] : junk_q;
  assign mrd_b = pv_b    ? mem[pa_b]    : junk_q;

  inter_read_slave #(
    .DATA_WIDTH(32), .SLAVE_ADDR_WIDTH(10), .WAIT_STATES(WS_A), .CACHE_EN(1)
  ) u_dut (
    .clk(clk), .reset(rst_n),
    .slave_data_req_i(req_a), .slave_data_addr_i(addr_a),
    .slave_data_rdata_o(rdata_a), .slave_data_gnt_o(gnt_a),
    .mem_en_o(en_a), .mem_addr_o(maddr_a), .mem_rdata_i(mrd_a),
    .invalidate_i(inv_a), .busy_o(busy_a)
  );

  inter_read_slave #(
    .DATA_WIDTH(32), .SLAVE_ADDR_WIDTH(10), .WAIT_STATES(0), .CACHE_EN(0)
  ) u_nc (
    .clk(clk), .reset(rst_n),
    .slave_data_req_i(req_b), .slave_data_addr_i(addr_b),
    .slave_data_rdata_o(rdata_b), .slave_data_gnt_o(gnt_b),
    .mem_en_o(en_b), .mem_addr_o(maddr_b), .mem_rdata_i(mrd_b),
    .invalidate_i(inv_b), .busy_o(busy_b)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model of the last-address buffer.
  logic        m_valid = 1'b0;
  logic [9:0]  m_tag   = '0;
  logic [31:0] m_data  = '0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One read on u_dut starting in an IDLE cycle; optional invalidate pulse and withdraw at response.
  task automatic xact(input logic [9:0] a, input int inv_at, input bit drop_resp);
    logic        hit;
    int          lat;
    logic [31:0] exp;
    hit = m_valid && (m_tag == a);
    lat = hit ? 1 : 2 + WS_A;
    exp = hit ? m_data : mem[a];
    addr_a = a;
    for (int c = 0; c <= lat; c++) begin
      inv_a = (c == inv_at);
      req_a = !(drop_resp && (c == lat));
      @(negedge clk);
      chk1("mem_en", en_a, (c == 0) && !hit);
      if (c == 0) chk32("mem_addr", 32'(maddr_a), 32'(a));
      chk1("busy", busy_a, c != 0);
      chk1("gnt", gnt_a, (c == lat) && !drop_resp);
      if ((c == lat) && !drop_resp) chk32("rdata", rdata_a, exp);
      if (!hit && (c == lat - 1)) begin
        m_valid = 1'b1;
        m_tag   = a;
        m_data  = mem[a];
      end
      if (c == inv_at) m_valid = 1'b0;
      next_cycle();
    end
    req_a = 1'b0;
    inv_a = 1'b0;
  endtask

  initial begin
    logic [9:0] a, wa;
    int         r, inv_at;
    bit         drop;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[10'h3FF] = 32'hDEADBEEF;
    mem[10'h005] = 32'h0000_5A5A;

    rst_n = 1'b0;
    req_a = 1'b1; addr_a = 10'h005; inv_a = 1'b0;
    req_b = 1'b0; addr_b = 10'h000; inv_b = 1'b0;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rst_gnt", gnt_a, 1'b0);
      chk1("rst_mem_en", en_a, 1'b0);
      chk1("rst_busy", busy_a, 1'b0);
      chk32("rst_rdata", rdata_a, 32'h0);
      next_cycle();
    end
    rst_n = 1'b1;
    xact(10'h005, -1, 1'b0);

    // No-buffer instance: every read goes to memory
    req_b = 1'b1; addr_b = 10'h001;
    for (int rd = 0; rd < 2; rd++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk1("nc_mem_en", en_b, c == 0);
        chk1("nc_gnt", gnt_b, c == 2);
        if (c == 2) chk32("nc_rdata", rdata_b, mem[1]);
        chk1("nc_buf_valid", u_nc.buf_valid_q, 1'b0);
        next_cycle();
      end
    end
    req_b = 1'b0;
    next_cycle();

    // Miss then hit at the top address
    xact(10'h3FF, -1, 1'b0);
    xact(10'h3FF, -1, 1'b0);

    // Abort by address change in WAIT
    req_a = 1'b1; addr_a = 10'h010;
    @(negedge clk); chk1("ab_mem_en", en_a, 1'b1);
    next_cycle();
    @(negedge clk); chk1("ab_busy", busy_a, 1'b1);
    next_cycle();
    addr_a = 10'h011;
    @(negedge clk);
    chk1("ab_gnt", gnt_a, 1'b0);
    chk1("ab_mem_en_wait", en_a, 1'b0);
    next_cycle();
    xact(10'h011, -1, 1'b0);

    // Abort by withdraw in WAIT; buffer must still hold 0x011
    req_a = 1'b1; addr_a = 10'h010;
    @(negedge clk); chk1("wd_mem_en", en_a, 1'b1);
    next_cycle();
    req_a = 1'b0;
    @(negedge clk);
    chk1("wd_gnt", gnt_a, 1'b0);
    chk1("wd_busy", busy_a, 1'b1);
    next_cycle();
    @(negedge clk); chk1("wd_idle", busy_a, 1'b0);
    next_cycle();
    xact(10'h011, -1, 1'b0);

    // Withdraw in RESP, then hit
    xact(10'h030, -1, 1'b1);
    @(negedge clk); chk1("resp_drop_idle", busy_a, 1'b0);
    next_cycle();
    xact(10'h030, -1, 1'b0);

    // Invalidate colliding with capture, then the same address misses
    xact(10'h020, 1 + WS_A, 1'b0);
    xact(10'h020, -1, 1'b0);

    // Reset mid-WAIT
    req_a = 1'b1; addr_a = 10'h040;
    @(negedge clk); chk1("rw_mem_en", en_a, 1'b1);
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk1("rw_busy", busy_a, 1'b0);
    chk1("rw_gnt", gnt_a, 1'b0);
    chk32("rw_rdata", rdata_a, 32'h0);
    m_valid = 1'b0;
    m_data  = '0;
    next_cycle();
    @(negedge clk);
    chk1("rw_hold_gnt", gnt_a, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    xact(10'h040, -1, 1'b0);

    // Randomized traffic against the buffer model
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      a = m_tag;
      else if (r < 7) a = 10'($urandom_range(0, 3));
      else            a = 10'($urandom);
      inv_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : -1;
      drop   = ($urandom_range(0, 7) == 0);
      xact(a, inv_at, drop);
      if ($urandom_range(0, 5) == 0) begin
        wa      = (m_valid && ($urandom_range(0, 1) == 1)) ? m_tag : 10'($urandom);
        mem[wa] = $urandom;
        inv_a   = 1'b1;
        @(negedge clk);
        chk1("wr_busy", busy_a, 1'b0);
        chk1("wr_gnt", gnt_a, 1'b0);
        m_valid = 1'b0;
        next_cycle();
        inv_a = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
